// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: each functional unit queues results in a private FIFO.
// One FIFO head per cycle is granted round-robin onto a single registered broadcast bus.
module cdb_arbiter #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned ROB_W = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  rob_clear,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*ROB_W-1:0] req_rob_id,
    input  logic [NREQ*32-1:0]    req_value,
    output logic [NREQ-1:0]       req_ready,
    output logic                  cdb_valid,
    output logic [ROB_W-1:0]      cdb_rob_id,
    output logic [31:0]           cdb_value,
    output logic [1:0]            cdb_src
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned VAL_W = 32;

    typedef struct packed {
        logic [ROB_W-1:0] rob_id;
        logic [VAL_W-1:0] value;
    } entry_t;

    entry_t           mem    [NREQ][DEPTH];
    logic [PTR_W-1:0] wr_ptr [NREQ];
    logic [PTR_W-1:0] rd_ptr [NREQ];
    logic [CNT_W-1:0] count  [NREQ];
    logic [IDX_W-1:0] last;

    logic [NREQ-1:0]  space_c;
    logic [NREQ-1:0]  push;
    logic [NREQ-1:0]  pop;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    entry_t           head;

    // Free space per FIFO, seen on registered counts only.
    always_comb begin
        space_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            space_c[i] = rdy_in && (count[i] < CNT_W'(DEPTH));
        end
    end

    // Reset forces ready low while it is held; counts are already cleared asynchronously.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = rst_in && space_c[i];
        end
    end

    // Round-robin search starting one past the last granted unit.
    always_comb begin
        int unsigned cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = 32'(last) + 32'(k);
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!grant_valid && (count[IDX_W'(cand)] != '0)) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        head = mem[grant_idx][rd_ptr[grant_idx]];
    end

    // A flush drops same-cycle pushes and suppresses the grant.
    always_comb begin
        push = '0;
        pop  = '0;
        for (int i = 0; i < NREQ; i++) begin
            push[i] = req_valid[i] && space_c[i] && !rob_clear;
            pop[i]  = rdy_in && !rob_clear && grant_valid && (grant_idx == IDX_W'(i));
        end
    end

    // FIFO bookkeeping and the broadcast register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NREQ; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            last       <= IDX_W'(NREQ - 1);
            cdb_valid  <= 1'b0;
            cdb_rob_id <= '0;
            cdb_value  <= '0;
            cdb_src    <= '0;
        end else if (rdy_in) begin
            if (rob_clear) begin
                for (int i = 0; i < NREQ; i++) begin
                    wr_ptr[i] <= '0;
                    rd_ptr[i] <= '0;
                    count[i]  <= '0;
                end
                cdb_valid <= 1'b0;
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (push[i]) begin
                        wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                    end
                    if (pop[i]) begin
                        rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                    end
                    if (push[i] && !pop[i]) begin
                        count[i] <= count[i] + CNT_W'(1);
                    end else if (!push[i] && pop[i]) begin
                        count[i] <= count[i] - CNT_W'(1);
                    end
                end
                if (grant_valid) begin
                    cdb_valid  <= 1'b1;
                    cdb_rob_id <= head.rob_id;
                    cdb_value  <= head.value;
                    cdb_src    <= 2'(grant_idx);
                    last       <= grant_idx;
                end else begin
                    cdb_valid <= 1'b0;
                end
            end
        end
    end

    // Payload storage needs no reset: counts alone decide what is live.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NREQ; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= '{rob_id: req_rob_id[i*ROB_W +: ROB_W],
                                       value:  req_value[i*VAL_W +: VAL_W]};
            end
        end
    end

endmodule
